// File: rtl/housekeeping_spi_sync_pkg.sv
// housekeeping_spi_sync_pkg: state encodings, command bit positions and SPI mode.
// Shared by housekeeping_spi_sync and hkspi_sync.
package housekeeping_spi_sync_pkg;

  localparam logic [2:0] HKSPI_ST_IDLE    = 3'd0;
  localparam logic [2:0] HKSPI_ST_COMMAND = 3'd1;
  localparam logic [2:0] HKSPI_ST_ADDRESS = 3'd2;
  localparam logic [2:0] HKSPI_ST_DATA    = 3'd3;
  localparam logic [2:0] HKSPI_ST_PASS    = 3'd4;

  localparam int HKSPI_CMD_WR     = 7;
  localparam int HKSPI_CMD_RD     = 6;
  localparam int HKSPI_CMD_CNT_HI = 5;
  localparam int HKSPI_CMD_CNT_LO = 3;
  localparam int HKSPI_CMD_MGMT   = 2;
  localparam int HKSPI_CMD_USER   = 1;

  localparam int HKSPI_SPI_MODE   = 0;

endpackage

// File: rtl/hkspi_sync.sv
// hkspi_sync: 2-flop synchronisers for SCK/CSB/SDI plus edge pulses.
// Ports: i_clk, i_rst_n; i_sck/i_csb/i_sdi pads; o_sdi_s, o_csb_s, o_sck_rise, o_sck_fall, o_csb_fall.
module hkspi_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sck,
  input  logic i_csb,
  input  logic i_sdi,
  output logic o_sdi_s,
  output logic o_csb_s,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_csb_fall
);

  logic [1:0] r_sck;
  logic [1:0] r_csb;
  logic [1:0] r_sdi;
  logic       r_sck_d;
  logic       r_csb_d;

  // CSB resets to the deselected level so reset never looks like a frame start
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sck   <= 2'b00;
      r_csb   <= 2'b11;
      r_sdi   <= 2'b00;
      r_sck_d <= 1'b0;
      r_csb_d <= 1'b1;
    end else begin
      r_sck   <= {r_sck[0], i_sck};
      r_csb   <= {r_csb[0], i_csb};
      r_sdi   <= {r_sdi[0], i_sdi};
      r_sck_d <= r_sck[1];
      r_csb_d <= r_csb[1];
    end
  end

  assign o_sdi_s    = r_sdi[1];
  assign o_csb_s    = r_csb[1];
  assign o_sck_rise = r_sck[1] & ~r_sck_d;
  assign o_sck_fall = ~r_sck[1] & r_sck_d;
  assign o_csb_fall = ~r_csb[1] & r_csb_d;

endmodule

// File: rtl/housekeeping_spi_sync.sv
// housekeeping_spi_sync: oversampled housekeeping SPI slave (cmd/addr/data framing).
// Ports: wb_clk_i/wb_rstn_i, SCK/CSB/SDI/SDO/sdoenb pads, addr/wdata/rdata/rdstb/wrstb bank side,
// busy, pass_thru_mgmt/pass_thru_user. Macro HKSPI_PASSTHRU_EN enables the PASS state.
module housekeeping_spi_sync
  import housekeeping_spi_sync_pkg::*;
#(
  parameter int ADDR_BYTES = 1,
  parameter int DATA_BYTES = 1,
  parameter int RD_LAT     = 2
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rstn_i,
  input  logic                    SCK,
  input  logic                    CSB,
  input  logic                    SDI,
  output logic                    SDO,
  output logic                    sdoenb,
  output logic [8*ADDR_BYTES-1:0] addr,
  output logic [8*DATA_BYTES-1:0] wdata,
  input  logic [8*DATA_BYTES-1:0] rdata,
  output logic                    rdstb,
  output logic                    wrstb,
  output logic                    busy,
  output logic                    pass_thru_mgmt,
  output logic                    pass_thru_user
);

  localparam int AW = 8*ADDR_BYTES;
  localparam int DW = 8*DATA_BYTES;
  localparam logic [5:0] C_LAST = 6'd7;
  localparam logic [5:0] A_LAST = 6'(AW-1);
  localparam logic [5:0] D_LAST = 6'(DW-1);

  logic w_sdi, w_csb, w_rise, w_fall, w_csb_fall;
  logic w_smp, w_shf, w_load, w_last_word, w_pass_st;

  logic [2:0]        r_state;
  logic [6:0]        r_cmd;
  logic [5:0]        r_bcnt;
  logic [2:0]        r_wcnt;
  logic [2:0]        r_nnn;
  logic              r_wr, r_rd;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_wdata;
  logic [DW-1:0]     r_sdo;
  logic              r_rdstb, r_wrstb;
  logic              r_inc, r_more, r_skip;
  logic [RD_LAT-1:0] r_lat;

  hkspi_sync u_sync (
    .i_clk      (wb_clk_i),
    .i_rst_n    (wb_rstn_i),
    .i_sck      (SCK),
    .i_csb      (CSB),
    .i_sdi      (SDI),
    .o_sdi_s    (w_sdi),
    .o_csb_s    (w_csb),
    .o_sck_rise (w_rise),
    .o_sck_fall (w_fall),
    .o_csb_fall (w_csb_fall)
  );

  assign w_smp = (HKSPI_SPI_MODE == 0) ? w_rise : w_fall;
  assign w_shf = (HKSPI_SPI_MODE == 0) ? w_fall : w_rise;

  assign w_load      = r_lat[RD_LAT-1] & (r_state == HKSPI_ST_DATA);
  assign w_last_word = (r_nnn != 3'd0) && ((r_wcnt + 3'd1) == r_nnn);

  // r_cmd holds command bits 7..1 once the 8th bit arrives (bit 0 is reserved)
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      r_state <= HKSPI_ST_IDLE;
      r_cmd   <= '0;
      r_bcnt  <= '0;
      r_wcnt  <= '0;
      r_nnn   <= '0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_sdo   <= '0;
      r_rdstb <= 1'b0;
      r_wrstb <= 1'b0;
      r_inc   <= 1'b0;
      r_more  <= 1'b0;
      r_skip  <= 1'b0;
      r_lat   <= '0;
    end else begin
      r_rdstb <= 1'b0;
      r_wrstb <= 1'b0;
      r_inc   <= 1'b0;
      r_lat   <= RD_LAT'({r_lat, r_rdstb});
      // cycle after the write strobe: advance address, then request next word
      if (r_inc) begin
        r_addr  <= r_addr + AW'(1);
        r_rdstb <= r_more & ~w_csb;
      end
      // fresh word arrives before the SCK fall that follows its request;
      // that fall must not shift away the MSB
      if (w_load) begin
        r_sdo  <= rdata;
        r_skip <= 1'b1;
      end
      if (w_csb) begin
        r_state <= HKSPI_ST_IDLE;
        r_bcnt  <= '0;
        r_sdo   <= '0;
        r_skip  <= 1'b0;
      end else begin
        unique case (r_state)
          HKSPI_ST_IDLE: begin
            if (w_csb_fall) begin
              r_state <= HKSPI_ST_COMMAND;
              r_bcnt  <= '0;
            end
          end
          HKSPI_ST_COMMAND: begin
            if (w_smp) begin
              r_cmd  <= {r_cmd[5:0], w_sdi};
              r_bcnt <= r_bcnt + 6'd1;
              if (r_bcnt == C_LAST) begin
                r_bcnt <= '0;
                r_wcnt <= '0;
                r_wr   <= r_cmd[HKSPI_CMD_WR-1];
                r_rd   <= r_cmd[HKSPI_CMD_RD-1];
                r_nnn  <= r_cmd[HKSPI_CMD_CNT_HI-1:HKSPI_CMD_CNT_LO-1];
`ifdef HKSPI_PASSTHRU_EN
                if (r_cmd[HKSPI_CMD_MGMT-1] | r_cmd[HKSPI_CMD_USER-1])
                  r_state <= HKSPI_ST_PASS;
                else
`endif
                if (r_cmd[HKSPI_CMD_WR-1] | r_cmd[HKSPI_CMD_RD-1])
                  r_state <= HKSPI_ST_ADDRESS;
                else
                  r_state <= HKSPI_ST_IDLE;
              end
            end
          end
          HKSPI_ST_ADDRESS: begin
            if (w_smp) begin
              r_addr <= {r_addr[AW-2:0], w_sdi};
              r_bcnt <= r_bcnt + 6'd1;
              if (r_bcnt == A_LAST) begin
                r_bcnt  <= '0;
                r_state <= HKSPI_ST_DATA;
                r_rdstb <= r_rd;
              end
            end
          end
          HKSPI_ST_DATA: begin
            if (w_shf && !w_load) begin
              if (r_skip) r_skip <= 1'b0;
              else        r_sdo  <= r_sdo << 1;
            end
            if (w_smp) begin
              r_wdata <= {r_wdata[DW-2:0], w_sdi};
              r_bcnt  <= r_bcnt + 6'd1;
              if (r_bcnt == D_LAST) begin
                r_bcnt  <= '0;
                r_wrstb <= r_wr;
                r_inc   <= 1'b1;
                r_wcnt  <= r_wcnt + 3'd1;
                if (w_last_word) begin
                  r_state <= HKSPI_ST_COMMAND;
                  r_more  <= 1'b0;
                end else begin
                  r_more  <= r_rd;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef HKSPI_PASSTHRU_EN
  logic r_pt_mgmt, r_pt_user;

  // mgmt wins when both pass bits are set
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      r_pt_mgmt <= 1'b0;
      r_pt_user <= 1'b0;
    end else if (!w_csb && w_smp && (r_state == HKSPI_ST_COMMAND)
                 && (r_bcnt == C_LAST)) begin
      r_pt_mgmt <= r_cmd[HKSPI_CMD_MGMT-1];
      r_pt_user <= r_cmd[HKSPI_CMD_USER-1] & ~r_cmd[HKSPI_CMD_MGMT-1];
    end
  end

  assign w_pass_st      = (r_state == HKSPI_ST_PASS);
  assign pass_thru_mgmt = w_pass_st & r_pt_mgmt;
  assign pass_thru_user = w_pass_st & r_pt_user;
`else
  logic w_unused_pt;

  assign w_unused_pt    = ^r_cmd[1:0];
  assign w_pass_st      = 1'b0;
  assign pass_thru_mgmt = 1'b0;
  assign pass_thru_user = 1'b0;
`endif

  assign SDO    = r_sdo[DW-1];
  assign sdoenb = ~(((r_state == HKSPI_ST_DATA) & r_rd) | w_pass_st);
  assign addr   = r_addr;
  assign wdata  = r_wdata;
  assign rdstb  = r_rdstb;
  assign wrstb  = r_wrstb;
  assign busy   = ~w_csb;

endmodule

// File: tb/tb_housekeeping_spi_sync.sv
// tb_housekeeping_spi_sync: directed frames against a default instance
// and a 16-bit address / 16-bit data instance.
module tb_housekeeping_spi_sync;

  localparam int H = 10;

`ifdef HKSPI_PASSTHRU_EN
  localparam logic PT_EXP = 1'b1;
`else
  localparam logic PT_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, sck, sdi, csb1, csb2;

  logic        sdo1, sdoenb1, rdstb1, wrstb1, busy1, ptm1, ptu1;
  logic [7:0]  addr1, wdata1, rdata1;
  logic        sdo2, sdoenb2, rdstb2, wrstb2, busy2, ptm2, ptu2;
  logic [15:0] addr2, wdata2, rdata2;

  assign rdata1 = addr1 ^ 8'h5A;
  assign rdata2 = 16'h0000;

  housekeeping_spi_sync u_dut1 (
    .wb_clk_i(clk), .wb_rstn_i(rstn), .SCK(sck), .CSB(csb1), .SDI(sdi),
    .SDO(sdo1), .sdoenb(sdoenb1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .rdstb(rdstb1), .wrstb(wrstb1), .busy(busy1),
    .pass_thru_mgmt(ptm1), .pass_thru_user(ptu1)
  );

  housekeeping_spi_sync #(
    .ADDR_BYTES(2), .DATA_BYTES(2), .RD_LAT(2)
  ) u_dut2 (
    .wb_clk_i(clk), .wb_rstn_i(rstn), .SCK(sck), .CSB(csb2), .SDI(sdi),
    .SDO(sdo2), .sdoenb(sdoenb2), .addr(addr2), .wdata(wdata2),
    .rdata(rdata2), .rdstb(rdstb2), .wrstb(wrstb2), .busy(busy2),
    .pass_thru_mgmt(ptm2), .pass_thru_user(ptu2)
  );

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int oe_cnt = 0;
  logic [15:0] wa1[$], wd1[$], wa2[$], wd2[$];

  always @(negedge clk) begin
    if (wrstb1) begin
      wa1.push_back({8'h00, addr1});
      wd1.push_back({8'h00, wdata1});
    end
    if (wrstb2) begin
      wa2.push_back(addr2);
      wd2.push_back(wdata2);
    end
    if (rdstb1) rd_cnt++;
    if (!sdoenb1) oe_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] qat(input logic [15:0] q[$], input int i);
    return (q.size() > i) ? q[i] : 16'hDEAD;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    wa1.delete(); wd1.delete(); wa2.delete(); wd2.delete();
    rd_cnt = 0;
    oe_cnt = 0;
  endtask

  task automatic bits(input logic [31:0] v, input int n,
                      output logic [31:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      sdi = v[i];
      tick(H);
      sck = 1'b1;
      rx = {rx[30:0], sdo1};
      tick(H);
      sck = 1'b0;
    end
  endtask

  logic [31:0] rx, rxa, rxb;

  initial begin
    rstn = 1'b0; sck = 1'b0; sdi = 1'b0; csb1 = 1'b1; csb2 = 1'b1;
    tick(5);
    chk("reset1", {sdo1, sdoenb1, busy1, rdstb1, wrstb1, ptm1, ptu1,
                   addr1, wdata1}, {7'b0100000, 16'h0000});
    chk("reset2", {sdo2, sdoenb2, busy2, rdstb2, wrstb2, ptm2, ptu2,
                   addr2, wdata2}, {7'b0100000, 32'h0});
    rstn = 1'b1;
    tick(5);

    // streaming write of two bytes
    clr();
    csb1 = 1'b0; tick(H);
    chk("busy_frame", busy1, 1'b1);
    bits(32'h80, 8, rx); bits(32'h10, 8, rx);
    bits(32'hA5, 8, rx); bits(32'h3C, 8, rx);
    tick(H); csb1 = 1'b1; tick(8);
    chk("wr_count", wa1.size(), 2);
    chk("wr_a0", qat(wa1, 0), 16'h0010);
    chk("wr_d0", qat(wd1, 0), 16'h00A5);
    chk("wr_a1", qat(wa1, 1), 16'h0011);
    chk("wr_d1", qat(wd1, 1), 16'h003C);
    chk("wr_oe_off", oe_cnt, 0);
    chk("busy_idle", busy1, 1'b0);

    // fixed-count read, then a write in the same frame
    clr();
    csb1 = 1'b0; tick(H);
    bits(32'h50, 8, rx); bits(32'hFE, 8, rx);
    bits(32'h00, 8, rxa); bits(32'h00, 8, rxb);
    tick(H);
    chk("rd_w0", rxa[7:0], 8'hA4);
    chk("rd_w1", rxb[7:0], 8'hA5);
    chk("rd_stb_count", rd_cnt, 2);
    chk("rd_oe_active", oe_cnt > 0, 1'b1);
    chk("rd_oe_done", sdoenb1, 1'b1);
    chk("rd_no_wr", wa1.size(), 0);
    bits(32'h80, 8, rx); bits(32'h20, 8, rx); bits(32'h77, 8, rx);
    tick(H); csb1 = 1'b1; tick(8);
    chk("recmd_count", wa1.size(), 1);
    chk("recmd_a", qat(wa1, 0), 16'h0020);
    chk("recmd_d", qat(wd1, 0), 16'h0077);

    // 16-bit address wrap
    clr();
    csb2 = 1'b0; tick(H);
    bits(32'h80, 8, rx); bits(32'hFFFF, 16, rx);
    bits(32'h1234, 16, rx); bits(32'hABCD, 16, rx);
    tick(H); csb2 = 1'b1; tick(8);
    chk("wrap_count", wa2.size(), 2);
    chk("wrap_a0", qat(wa2, 0), 16'hFFFF);
    chk("wrap_d0", qat(wd2, 0), 16'h1234);
    chk("wrap_a1", qat(wa2, 1), 16'h0000);
    chk("wrap_d1", qat(wd2, 1), 16'hABCD);
    chk("wrap_dut1_quiet", wa1.size(), 0);

    // abort after 5 bits of a read/write word
    clr();
    csb1 = 1'b0; tick(H);
    bits(32'hC0, 8, rx); bits(32'h30, 8, rx); bits(32'h16, 5, rx);
    tick(H);
    chk("abort_oe_before", sdoenb1, 1'b0);
    csb1 = 1'b1;
    tick(3);
    chk("abort_oe_after", sdoenb1, 1'b1);
    chk("abort_busy", busy1, 1'b0);
    tick(8);
    chk("abort_no_wr", wa1.size(), 0);
    chk("abort_rd_once", rd_cnt, 1);

    // pass-through command
    clr();
    csb1 = 1'b0; tick(H);
    bits(32'hC4, 8, rx);
    tick(30);
    chk("pt_mgmt", ptm1, PT_EXP);
    chk("pt_user", ptu1, 1'b0);
    chk("pt_no_stb", rd_cnt + wa1.size(), 0);
    csb1 = 1'b1; tick(8);
    chk("pt_mgmt_clear", ptm1, 1'b0);

    // pass-only command followed by data bytes
    clr();
    csb1 = 1'b0; tick(H);
    bits(32'h04, 8, rx); bits(32'h12, 8, rx); bits(32'h34, 8, rx);
    tick(H);
    chk("pt04_no_stb", rd_cnt + wa1.size(), 0);
    csb1 = 1'b1; tick(8);

    // reset in the middle of a read data word
    clr();
    csb1 = 1'b0; tick(H);
    bits(32'hC0, 8, rx); bits(32'h42, 8, rx); bits(32'h5, 3, rx);
    tick(2);
    chk("mid_addr", addr1, 8'h42);
    #2 rstn = 1'b0;
    #1;
    chk("mid_reset", {sdo1, sdoenb1, busy1, rdstb1, wrstb1, ptm1, ptu1,
                      addr1, wdata1}, {7'b0100000, 16'h0000});
    csb1 = 1'b1; sck = 1'b0;
    tick(4);
    rstn = 1'b1;
    tick(4);
    clr();
    csb1 = 1'b0; tick(H);
    bits(32'h80, 8, rx); bits(32'h55, 8, rx); bits(32'h99, 8, rx);
    tick(H); csb1 = 1'b1; tick(8);
    chk("post_rst_count", wa1.size(), 1);
    chk("post_rst_a", qat(wa1, 0), 16'h0055);
    chk("post_rst_d", qat(wd1, 0), 16'h0099);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
